// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Frame sequencer for the unrolled FFT datapath and its I/Q sample delay line.
//   Gates the delay-line shift so that exactly N accepted samples form a frame,
//   pulses fft_start once the frame is complete, waits out the FFT pipeline
//   latency, pulses result_valid and counts completed frames.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   enable       run request; 0 stops accepting new frames (in-flight frame completes)
//   s_valid      input sample valid (sample data does not pass through this block)
//   s_ready      sample accepted when s_valid & s_ready
//   shift_en     delay-line shift enable (= s_valid & s_ready)
//   fft_start    1-cycle pulse: delay line holds a complete frame
//   result_valid 1-cycle pulse: FFT outputs belong to the current frame
//   busy         high in FILL, RUN, DONE
//   frame_cnt    completed frame count, wraps
//   overrun      sticky: sample offered while in RUN/DONE
module fft_frame_ctrl #(
    parameter int N   = 32,
    parameter int LAT = 8,
    parameter int FCW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           s_valid,
    output logic           s_ready,
    output logic           shift_en,
    output logic           fft_start,
    output logic           result_valid,
    output logic           busy,
    output logic [FCW-1:0] frame_cnt,
    output logic           overrun
);

    localparam int SW = (N   > 1) ? $clog2(N)   : 1;
    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  samp_cnt_q, samp_cnt_d;
    logic [LW-1:0]  lat_cnt_q, lat_cnt_d;
    logic           fft_start_q, fft_start_d;
    logic           result_valid_q, result_valid_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            samp_cnt_q     <= '0;
            lat_cnt_q      <= '0;
            fft_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            frame_cnt_q    <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            samp_cnt_q     <= samp_cnt_d;
            lat_cnt_q      <= lat_cnt_d;
            fft_start_q    <= fft_start_d;
            result_valid_q <= result_valid_d;
            frame_cnt_q    <= frame_cnt_d;
            overrun_q      <= overrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        samp_cnt_d     = samp_cnt_q;
        lat_cnt_d      = lat_cnt_q;
        fft_start_d    = 1'b0;
        result_valid_d = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        overrun_d      = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = FILL;
            end
            FILL: begin
                if (!enable) begin
                    // Dropping enable discards the partial frame, even on the would-be last sample.
                    state_d    = IDLE;
                    samp_cnt_d = '0;
                end else if (s_valid) begin
                    if (samp_cnt_q == SW'(N - 1)) begin
                        samp_cnt_d  = '0;
                        lat_cnt_d   = '0;
                        fft_start_d = 1'b1;
                        state_d     = RUN;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (s_valid) overrun_d = 1'b1;
                if (lat_cnt_q == LW'(LAT - 1)) begin
                    // Registered so the pulse lands in the DONE cycle.
                    lat_cnt_d      = '0;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (s_valid) overrun_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = enable ? FILL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready      = (state_q == FILL) && enable;
    assign shift_en     = s_valid && s_ready;
    assign busy         = (state_q != IDLE);
    assign fft_start    = fft_start_q;
    assign result_valid = result_valid_q;
    assign frame_cnt    = frame_cnt_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
module tb_fft_frame_ctrl;
    localparam int N   = 32;
    localparam int LAT = 8;
    localparam int FCW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1, enable = 1'b0, s_valid = 1'b0;
    logic s_ready, shift_en, fft_start, result_valid, busy, overrun;
    logic [FCW-1:0] frame_cnt;

    fft_frame_ctrl #(.N(N), .LAT(LAT), .FCW(FCW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid),
        .s_ready(s_ready), .shift_en(shift_en), .fft_start(fft_start),
        .result_valid(result_valid), .busy(busy), .frame_cnt(frame_cnt),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is described by the cycle of its last accepted
    // sample; every later event is a fixed offset from that timestamp.
    int cyc = 0;
    bit m_fill = 0;
    int m_cnt = 0;
    int m_last = -1;
    logic [FCW-1:0] m_frames = '0;
    bit m_ovr = 0;

    // {s_ready, shift_en, fft_start, result_valid, busy, overrun}
    logic [5:0] exp_v, obs_v;
    logic [FCW-1:0] exp_fc, obs_fc;
    int obs_cyc;

    task automatic tick();
        bit has, in_rd, rd;
        @(negedge clk);
        has   = (m_last >= 0);
        in_rd = has && (cyc > m_last) && (cyc <= m_last + LAT + 1);
        rd    = m_fill && enable;
        exp_v = {rd, s_valid && rd, has && (cyc == m_last + 1),
                 has && (cyc == m_last + LAT + 1), m_fill || in_rd, m_ovr};
        exp_fc = m_frames;
        obs_v  = {s_ready, shift_en, fft_start, result_valid, busy, overrun};
        obs_fc = frame_cnt;
        obs_cyc = cyc;
        @(posedge clk);
        if (reset) begin
            m_fill = 0; m_cnt = 0; m_last = -1; m_frames = '0; m_ovr = 0;
        end else if (m_fill) begin
            if (!enable) begin
                m_fill = 0; m_cnt = 0;
            end else if (s_valid) begin
                m_cnt++;
                if (m_cnt == N) begin
                    m_cnt = 0; m_fill = 0; m_last = cyc;
                end
            end
        end else if (in_rd) begin
            if (s_valid) m_ovr = 1;
            if (cyc == m_last + LAT + 1) begin
                m_frames = m_frames + 1'b1;
                m_fill = enable;
            end
        end else if (enable) begin
            m_fill = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; s_valid = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; s_valid = 1;
        tick(); tick();
        checks++;
        if (obs_v !== 6'b0) begin
            errors++; $display("FAIL reset_outputs got=%b want=000000", obs_v);
        end
        checks++;
        if (obs_fc !== '0) begin
            errors++; $display("FAIL reset_frame_cnt got=%0d want=0", obs_fc);
        end
        reset = 0; enable = 0; s_valid = 0;
    endtask

    task automatic test_single_frame();
        int acc = 0, last_sh = -1, st = -1, rv = -1;
        do_reset();
        enable = 1;
        for (int i = 0; i < 120 && rv < 0; i++) begin
            s_valid = (acc < N);
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL single_vec cyc=%0d got=%b want=%b", obs_cyc, obs_v, exp_v);
            end
            if (obs_v[4]) begin acc++; last_sh = obs_cyc; end
            if (obs_v[3] && st < 0) st = obs_cyc;
            if (obs_v[2]) rv = obs_cyc;
        end
        checks++;
        if (acc != N) begin errors++; $display("FAIL single_shifts got=%0d want=%0d", acc, N); end
        checks++;
        if (st != last_sh + 1) begin errors++; $display("FAIL single_start_cyc got=%0d want=%0d", st, last_sh + 1); end
        checks++;
        if (rv != last_sh + LAT + 1) begin errors++; $display("FAIL single_rv_cyc got=%0d want=%0d", rv, last_sh + LAT + 1); end
        s_valid = 0; enable = 0;
        tick();
        checks++;
        if (obs_fc !== 16'd1 || obs_v[0] !== 1'b0) begin
            errors++; $display("FAIL single_cnt_ovr got fc=%0d ovr=%b want fc=1 ovr=0", obs_fc, obs_v[0]);
        end
        tick();
    endtask

    task automatic test_gaps();
        bit pat[50];
        int acc = 0, starts = 0, early = 0, rv = 0;
        for (int i = 0; i < 50; i++) pat[i] = (i < N);
        for (int i = 49; i > 0; i--) begin
            int j; bit t;
            j = $urandom_range(i, 0);
            t = pat[i]; pat[i] = pat[j]; pat[j] = t;
        end
        do_reset();
        enable = 1; s_valid = 0;
        tick();
        for (int i = 0; i < 50 + LAT + 4; i++) begin
            s_valid = (i < 50) ? pat[i] : 1'b0;
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL gaps_vec cyc=%0d got=%b want=%b", obs_cyc, obs_v, exp_v);
            end
            if (obs_v[3]) begin starts++; if (acc < N) early++; end
            if (obs_v[4]) acc++;
            if (obs_v[2]) rv++;
        end
        checks++;
        if (acc != N) begin errors++; $display("FAIL gaps_shifts got=%0d want=%0d", acc, N); end
        checks++;
        if (starts != 1 || early != 0) begin
            errors++; $display("FAIL gaps_start got starts=%0d early=%0d want 1/0", starts, early);
        end
        checks++;
        if (rv != 1) begin errors++; $display("FAIL gaps_rv got=%0d want=1", rv); end
        enable = 0; tick();
    endtask

    task automatic test_overrun();
        int st = -1, rv = -1;
        do_reset();
        enable = 1; s_valid = 1;
        for (int i = 0; i < 80 && rv < 0; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL ovr_vec cyc=%0d got=%b want=%b", obs_cyc, obs_v, exp_v);
            end
            if (obs_v[3] && st < 0) st = obs_cyc;
            if (st >= 0) begin
                checks++;
                if (obs_v[5] !== 1'b0) begin errors++; $display("FAIL ovr_ready_run cyc=%0d got=1 want=0", obs_cyc); end
            end
            if (st >= 0 && obs_cyc > st) begin
                checks++;
                if (obs_v[0] !== 1'b1) begin errors++; $display("FAIL ovr_flag cyc=%0d got=0 want=1", obs_cyc); end
            end
            if (obs_v[2]) rv = obs_cyc;
        end
        checks++;
        if (rv < 0) begin errors++; $display("FAIL ovr_timeout got no result_valid want one"); end
        enable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs_v[0] !== 1'b1) begin errors++; $display("FAIL ovr_sticky cyc=%0d got=0 want=1", obs_cyc); end
        end
        do_reset(); tick();
        checks++;
        if (obs_v[0] !== 1'b0) begin errors++; $display("FAIL ovr_clear got=1 want=0"); end
    endtask

    task automatic test_abort();
        int acc = 0, st = -1, rv = -1;
        do_reset();
        enable = 1;
        for (int i = 0; i < 40 && acc < 10; i++) begin
            s_valid = 1; tick();
            if (obs_v[4]) acc++;
        end
        enable = 0; s_valid = 1;
        tick(); tick();
        checks++;
        if (obs_v[1] !== 1'b0) begin errors++; $display("FAIL abort_busy got=1 want=0"); end
        acc = 0;
        enable = 1;
        for (int i = 0; i < 200 && rv < 0; i++) begin
            s_valid = (st < 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL abort_vec cyc=%0d got=%b want=%b", obs_cyc, obs_v, exp_v);
            end
            if (obs_v[3] && st < 0) begin
                st = obs_cyc;
                checks++;
                if (acc != N) begin errors++; $display("FAIL abort_refill got=%0d want=%0d", acc, N); end
            end
            if (obs_v[4]) acc++;
            if (obs_v[2]) rv = obs_cyc;
        end
        enable = 0; s_valid = 0;
        tick();
        checks++;
        if (obs_fc !== 16'd1) begin errors++; $display("FAIL abort_frame_cnt got=%0d want=1", obs_fc); end
        tick();
    endtask

    task automatic test_reset_mid();
        int acc = 0, rv = 0;
        do_reset();
        enable = 1;
        for (int i = 0; i < 60 && acc < N; i++) begin
            s_valid = 1; tick();
            if (obs_v[4]) acc++;
        end
        s_valid = 0;
        tick(); tick(); tick();
        checks++;
        if (obs_v[1] !== 1'b1) begin errors++; $display("FAIL mid_in_run busy got=0 want=1"); end
        reset = 1; tick();
        reset = 0; enable = 0;
        tick();
        checks++;
        if (obs_v !== 6'b0 || obs_fc !== '0) begin
            errors++; $display("FAIL mid_reset got=%b fc=%0d want=000000 fc=0", obs_v, obs_fc);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs_v[2]) rv++;
        end
        checks++;
        if (rv != 0) begin errors++; $display("FAIL mid_no_rv got=%0d want=0", rv); end
    endtask

    task automatic test_back_to_back();
        int st[$];
        int nrv = 0;
        bit prev_rv = 0;
        do_reset();
        enable = 1; s_valid = 1;
        for (int i = 0; i < 250 && nrv < 3; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL b2b_vec cyc=%0d got=%b want=%b", obs_cyc, obs_v, exp_v);
            end
            if (prev_rv) begin
                checks++;
                if (obs_v[5] !== 1'b1) begin errors++; $display("FAIL b2b_refill cyc=%0d ready got=0 want=1", obs_cyc); end
            end
            prev_rv = obs_v[2];
            if (obs_v[3]) st.push_back(obs_cyc);
            if (obs_v[2]) nrv++;
        end
        checks++;
        if (st.size() < 3) begin
            errors++; $display("FAIL b2b_starts got=%0d want>=3", st.size());
        end else if (st[1] - st[0] != N + LAT + 1 || st[2] - st[1] != N + LAT + 1) begin
            errors++; $display("FAIL b2b_spacing got=%0d,%0d want=%0d", st[1] - st[0], st[2] - st[1], N + LAT + 1);
        end
        enable = 0; s_valid = 0;
        tick();
        checks++;
        if (obs_fc !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt got=%0d want=3", obs_fc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            enable  = ($urandom_range(7, 0) != 0);
            s_valid = ($urandom_range(3, 0) != 0);
            reset   = ($urandom_range(299, 0) == 0);
            tick();
            checks++;
            if (obs_v !== exp_v || obs_fc !== exp_fc) begin
                errors++;
                $display("FAIL rand_vec cyc=%0d got=%b fc=%0d want=%b fc=%0d", obs_cyc, obs_v, obs_fc, exp_v, exp_fc);
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gaps();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog");
    end
endmodule
